// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forward-select encoding,
// the per-stage destination tag slot, and a bubble constructor.
package hazard_pkg;

  // Widest register address a slot can carry; narrower addresses are zero-extended.
  localparam int SLOT_RD_W = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 we;
    logic                 is_load;
    logic                 is_mem;
  } slot_t;

  function automatic slot_t bubble_slot();
    slot_t s;
    s = '0;
    return s;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID operand info, branch and
// memory status in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 2,
  parameter int CNT_W      = 16
);
  import hazard_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_we;
  logic                  id_is_load;
  logic                  id_is_mem;
  logic                  ex_branch_taken;
  logic                  mem_ready;

  logic                  stall_if_id;
  logic                  bubble_ex;
  logic                  freeze;
  logic                  flush;
  fwd_sel_t              fwd_a_sel;
  fwd_sel_t              fwd_b_sel;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
           id_is_load, id_is_mem, ex_branch_taken, mem_ready,
    input  stall_if_id, bubble_ex, freeze, flush, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
           id_is_load, id_is_mem, ex_branch_taken, mem_ready,
    output stall_if_id, bubble_ex, freeze, flush, fwd_a_sel, fwd_b_sel, stall_count
  );

endinterface

// File: rtl/hazard_slot_pipe.sv
// Three-deep shadow of the destination tags held in EX, MEM and WB.
// Shifts on every non-held edge; EX takes either the ID tag or a bubble.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold_i,
  input  logic  load_ex_i,
  input  slot_t id_slot_i,
  output slot_t ex_o,
  output slot_t mem_o,
  output slot_t wb_o
);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;

  // EX entry: real ID tag only when the instruction actually advances.
  always_comb begin
    ex_d = load_ex_i ? id_slot_i : bubble_slot();
  end

  // Tag shift register; hold keeps all three stages in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= bubble_slot();
      mem_q <= bubble_slot();
      wb_q  <= bubble_slot();
    end else if (!hold_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the in-order five-stage pipeline.
// Produces forward selects, load-use stall, memory freeze, branch flush and
// a saturating stalled-cycle counter from a registered tag shadow.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W         = 2,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int FLUSH_CYCLES       = 1,
  parameter int CNT_W              = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit.
  localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  slot_t           id_slot, ex_s, mem_s, wb_s;
  logic            m_ex_a, m_mem_a, m_wb_a;
  logic            m_ex_b, m_mem_b, m_wb_b;
  logic            mem_wait, freeze_c, flush_c, load_use_c, load_ex;
  fwd_sel_t        fwd_a, fwd_b;
  logic [FC_W-1:0] flush_ctr_q, flush_ctr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            unused_slot_bits;

  function automatic logic slot_match(slot_t s, logic [REG_ADDR_W-1:0] rs, logic used);
    logic zero_blk;
    zero_blk = (ZERO_REG_HARDWIRED != 0) && (rs == '0);
    return s.valid & s.we & used & (s.rd == SLOT_RD_W'(rs)) & ~zero_blk;
  endfunction

  // Youngest producer wins; a load still in EX has no data to forward yet.
  function automatic fwd_sel_t pick_fwd(logic m_ex, logic m_mem, logic m_wb, logic ex_load);
    if (m_ex)       return ex_load ? FWD_NONE : FWD_EX;
    else if (m_mem) return FWD_MEM;
    else if (m_wb)  return FWD_WB;
    else            return FWD_NONE;
  endfunction

  // Pack the ID instruction into a tag slot.
  always_comb begin
    id_slot         = bubble_slot();
    id_slot.valid   = bus.id_valid;
    id_slot.rd      = SLOT_RD_W'(bus.id_rd);
    id_slot.we      = bus.id_rd_we;
    id_slot.is_load = bus.id_is_load;
    id_slot.is_mem  = bus.id_is_mem;
  end

  hazard_slot_pipe u_slots (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_i    (freeze_c),
    .load_ex_i (load_ex),
    .id_slot_i (id_slot),
    .ex_o      (ex_s),
    .mem_o     (mem_s),
    .wb_o      (wb_s)
  );

  // Operand matching, priority resolution (freeze > flush > load-use) and forwarding.
  always_comb begin
    m_ex_a  = slot_match(ex_s,  bus.id_rs1, bus.id_rs1_used);
    m_mem_a = slot_match(mem_s, bus.id_rs1, bus.id_rs1_used);
    m_wb_a  = slot_match(wb_s,  bus.id_rs1, bus.id_rs1_used);
    m_ex_b  = slot_match(ex_s,  bus.id_rs2, bus.id_rs2_used);
    m_mem_b = slot_match(mem_s, bus.id_rs2, bus.id_rs2_used);
    m_wb_b  = slot_match(wb_s,  bus.id_rs2, bus.id_rs2_used);

    mem_wait   = mem_s.valid & mem_s.is_mem & ~bus.mem_ready;
    freeze_c   = mem_wait;
    flush_c    = ~freeze_c & (bus.ex_branch_taken | (flush_ctr_q != '0));
    load_use_c = ~freeze_c & ~flush_c & bus.id_valid & ex_s.is_load & (m_ex_a | m_ex_b);
    load_ex    = bus.id_valid & ~load_use_c & ~flush_c;

    fwd_a = pick_fwd(m_ex_a, m_mem_a, m_wb_a, ex_s.is_load);
    fwd_b = pick_fwd(m_ex_b, m_mem_b, m_wb_b, ex_s.is_load);
  end

  // Next flush count; a branch honoured while running restarts the window.
  always_comb begin
    flush_ctr_d = flush_ctr_q;
    if (!freeze_c) begin
      if (bus.ex_branch_taken)      flush_ctr_d = FC_LOAD;
      else if (flush_ctr_q != '0)   flush_ctr_d = flush_ctr_q - FC_W'(1);
    end
  end

  // Next stalled-cycle count, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((freeze_c | load_use_c) && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Flush window and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_ctr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_ctr_q <= flush_ctr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are forced low while reset is asserted, even if inputs are active.
  always_comb begin
    bus.freeze      = rst_n & freeze_c;
    bus.flush       = rst_n & flush_c;
    bus.stall_if_id = rst_n & load_use_c;
    bus.bubble_ex   = rst_n & load_use_c;
    bus.fwd_a_sel   = rst_n ? fwd_a : FWD_NONE;
    bus.fwd_b_sel   = rst_n ? fwd_b : FWD_NONE;
    bus.stall_count = stall_cnt_q;
  end

  assign unused_slot_bits = ^{ex_s.is_mem, mem_s.is_load, wb_s.is_load, wb_s.is_mem};

endmodule
